sparse_sel_sched: RTL

Sequencing controller for the 8-to-4 activation selector in the sparse tensor core. Per tile, it accepts a stream of 2:4 sparsity metadata bytes and a stream of 64-bit activation groups. It pairs them one-to-one, checks that each metadata nibble is legal, and issues registered `{activation_group, sel}` pairs to the selector stage through a valid/ready handshake. It counts groups per tile and signals tile completion.

---
 rtl/sparse_sel_sched.sv | 127 ++++++++++++
 1 files changed

// File: rtl/sparse_sel_sched.sv
// Sequencer for the 8-to-4 activation selector: pairs 2:4 metadata bytes with
// 64-bit activation groups, checks nibble legality and counts groups per tile.
module sparse_sel_sched #(
    parameter int META_DEPTH = 4,
    parameter int GCNT_W     = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_start,
    input  logic [GCNT_W-1:0] cfg_num_groups,
    output logic              busy,
    input  logic              meta_valid,
    output logic              meta_ready,
    input  logic [7:0]        meta_data,
    input  logic              act_valid,
    output logic              act_ready,
    input  logic [63:0]       act_data,
    output logic              mux_valid,
    input  logic              mux_ready,
    output logic [63:0]       mux_act,
    output logic [7:0]        mux_sel,
    output logic [GCNT_W-1:0] grp_idx,
    output logic              tile_done,
    output logic              meta_err
);
    localparam int AW = $clog2(META_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
    state_t state, state_nxt;

    logic [GCNT_W-1:0] n_q, meta_cnt, issue_cnt, cons_cnt;
    logic [7:0]        fifo [META_DEPTH];
    logic [AW:0]       wr_ptr, rd_ptr;
    logic [7:0]        head;
    logic              fifo_empty, fifo_full, run, start, push, pop, out_hs;

    // A nibble names two kept lanes of four; they must be strictly ascending.
    function automatic logic nib_ok(input logic [3:0] nb);
        return nb[1:0] < nb[3:2];
    endfunction

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign head       = fifo[rd_ptr[AW-1:0]];

    assign run        = (state == S_RUN);
    assign start      = (state == S_IDLE) && cfg_start;
    assign busy       = (state != S_IDLE);
    assign tile_done  = (state == S_DONE);
    assign meta_ready = run && !fifo_full && (meta_cnt < n_q);
    assign act_ready  = run && !fifo_empty && (issue_cnt < n_q) && (!mux_valid || mux_ready);
    assign push       = meta_valid && meta_ready;
    assign pop        = act_valid && act_ready;
    assign out_hs     = mux_valid && mux_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (cfg_start) state_nxt = (cfg_num_groups == '0) ? S_DONE : S_RUN;
            S_RUN:  if (out_hs && (GCNT_W'(cons_cnt + 1'b1) == n_q)) state_nxt = S_DONE;
            S_DONE: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            n_q       <= '0;
            meta_cnt  <= '0;
            issue_cnt <= '0;
            cons_cnt  <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
        end else if (start) begin
            n_q       <= cfg_num_groups;
            meta_cnt  <= '0;
            issue_cnt <= '0;
            cons_cnt  <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
        end else begin
            if (push) begin
                meta_cnt <= meta_cnt + 1'b1;
                wr_ptr   <= wr_ptr + 1'b1;
            end
            if (pop) begin
                issue_cnt <= issue_cnt + 1'b1;
                rd_ptr    <= rd_ptr + 1'b1;
            end
            if (out_hs) cons_cnt <= cons_cnt + 1'b1;
        end
    end

    // Storage needs no reset; emptiness is carried by the pointers alone.
    always_ff @(posedge clk) begin
        if (push) fifo[wr_ptr[AW-1:0]] <= meta_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mux_valid <= 1'b0;
            mux_act   <= '0;
            mux_sel   <= '0;
            grp_idx   <= '0;
        end else if (pop) begin
            mux_valid <= 1'b1;
            mux_act   <= act_data;
            mux_sel   <= head;
            grp_idx   <= issue_cnt;
        end else if (out_hs) begin
            mux_valid <= 1'b0;
        end
    end

    // Illegal metadata is flagged but the pair still goes out untouched.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)        meta_err <= 1'b0;
        else if (start) meta_err <= 1'b0;
        else if (pop && (!nib_ok(head[3:0]) || !nib_ok(head[7:4]))) meta_err <= 1'b1;
    end

endmodule
